// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer state encoding and instruction-length decode
// helpers for the 8-bit CPU control path.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_OPERAND  = 3'd2,
        S_EXEC_MEM = 3'd3,
        S_EXEC     = 3'd4,
        S_HALT     = 3'd5
    } seq_state_e;

    // Opcodes 1..8 carry an operand byte at PC+1.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op >= OP_LDA) && (op <= OP_JZ);
    endfunction

    // Opcodes 1..4 make a data-memory access through the operand address.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= OP_LDA) && (op <= OP_STA);
    endfunction

endpackage

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute control for the 8-bit CPU. Strobes are
// combinational from state, IR and mem_ready; only state, IR and operand are stored.
module fetch_exec_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic             flag_c,
    input  logic             flag_z,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_load_val,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_load,
    output logic [WIDTH-1:0] ir,
    output logic             a_load,
    output logic             a_src,
    output logic             alu_load,
    output logic             alu_sub,
    output logic             out_load,
    output logic             halted
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] opr_q, opr_d;
    logic [OPW-1:0]   op;

    assign op = ir_q[WIDTH-1 -: OPW];
    assign ir = ir_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        opr_d       = opr_q;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ir_load     = 1'b0;
        a_load      = 1'b0;
        a_src       = 1'b0;
        alu_load    = 1'b0;
        alu_sub     = 1'b0;
        out_load    = 1'b0;
        halted      = 1'b0;
        // Gating on reset drops any in-flight request in the same cycle reset asserts.
        if (reset) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_addr = pc;
                    mem_rd   = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        ir_d    = mem_rdata;
                        pc_inc  = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_two_byte(op)) begin
                        state_d = S_OPERAND;
                    end else if (op == OP_OUT) begin
                        out_load = 1'b1;
                        state_d  = S_FETCH;
                    end else if (op == OP_HLT) begin
                        halted  = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_OPERAND: begin
                    mem_addr = pc;
                    mem_rd   = 1'b1;
                    if (mem_ready) begin
                        opr_d   = mem_rdata;
                        pc_inc  = 1'b1;
                        state_d = is_mem_op(op) ? S_EXEC_MEM : S_EXEC;
                    end
                end
                S_EXEC_MEM: begin
                    mem_addr = opr_q;
                    if (op == OP_STA) mem_wr = 1'b1;
                    else              mem_rd = 1'b1;
                    if (mem_ready) begin
                        unique case (op)
                            OP_LDA:  a_load = 1'b1;
                            OP_ADD:  alu_load = 1'b1;
                            OP_SUB: begin
                                alu_load = 1'b1;
                                alu_sub  = 1'b1;
                            end
                            default: ;
                        endcase
                        state_d = S_FETCH;
                    end
                end
                S_EXEC: begin
                    unique case (op)
                        OP_LDI: begin
                            a_load = 1'b1;
                            a_src  = 1'b1;
                        end
                        OP_JMP: begin
                            pc_load     = 1'b1;
                            pc_load_val = opr_q;
                        end
                        OP_JC: begin
                            pc_load     = flag_c;
                            pc_load_val = opr_q;
                        end
                        OP_JZ: begin
                            pc_load     = flag_z;
                            pc_load_val = opr_q;
                        end
                        default: ;
                    endcase
                    state_d = S_FETCH;
                end
                S_HALT:  halted = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            opr_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
        end
    end

endmodule

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit computer. It drives the program counter (load/increment strobes), memory read/write with a ready handshake, the instruction register, the accumulator/ALU load enables and the output register.
- It replaces free-running PC behaviour: the PC advances only on this block's strobes.
- It sits between the instruction register/flags and the datapath, one instance per CPU.

Parameters:
- WIDTH, 8, data/address width.
- OPW, 4, opcode width (instruction byte bits [WIDTH-1:WIDTH-OPW]).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc  in  WIDTH  current PC value.
- mem_rdata  in  WIDTH  memory read data.
- mem_ready  in  1  memory completes the current access this cycle.
- flag_c  in  1  ALU carry flag.
- flag_z  in  1  ALU zero flag.
- pc_inc  out  1  PC increment strobe (one cycle).
- pc_load  out  1  PC parallel-load strobe.
- pc_load_val  out  WIDTH  PC load value.
- mem_addr  out  WIDTH  memory address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- ir_load  out  1  IR captures mem_rdata.
- ir  out  WIDTH  latched instruction byte.
- a_load  out  1  accumulator load.
- a_src  out  1  0 = mem_rdata, 1 = operand register.
- alu_load  out  1  accumulator <= ALU result.
- alu_sub  out  1  0 = add, 1 = subtract.
- out_load  out  1  output register <= accumulator.
- halted  out  1  HLT executed.

Behaviour:
- Opcodes (ir[7:4]):
  - NOP=0, LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=E, HLT=F.
  - 9..D are undefined and execute as NOP.
- Operand bytes: 1..8 take one operand byte at PC+1. All others are single-byte.
- States: FETCH, DECODE, OPERAND, EXEC_MEM, EXEC, HALT.
- Reset (reset=0, async):
  - state=FETCH, ir=0, operand reg=0.
  - All strobes 0; mem_addr=0; halted=0.
  - Takes effect immediately, including mid-access. Any pending mem_rd/mem_wr drops the same cycle.
- FETCH: mem_addr=pc, mem_rd=1. Held until mem_ready=1. On that cycle: ir_load=1, ir<=mem_rdata, pc_inc=1, then go to DECODE.
- DECODE (1 cycle, no memory activity):
  - Operand opcodes go to OPERAND.
  - OUT: out_load=1, go to FETCH.
  - HLT: go to HALT.
  - NOP/undefined: go to FETCH.
- OPERAND: mem_addr=pc, mem_rd=1 until mem_ready. On the ready cycle: opr<=mem_rdata, pc_inc=1.
  - LDA/ADD/SUB/STA go to EXEC_MEM.
  - Others go to EXEC.
- EXEC_MEM: mem_addr=opr.
  - LDA/ADD/SUB: mem_rd=1.
  - STA: mem_wr=1.
  - Held until mem_ready. On the ready cycle:
    - LDA: a_load=1, a_src=0.
    - ADD: alu_load=1, alu_sub=0.
    - SUB: alu_load=1, alu_sub=1.
    - STA: no extra strobe.
  - Then go to FETCH.
- EXEC (1 cycle), then go to FETCH:
  - LDI: a_load=1, a_src=1.
  - JMP: pc_load=1, pc_load_val=opr.
  - JC: pc_load=flag_c.
  - JZ: pc_load=flag_z.
  - pc_load_val=opr whenever the opcode is a jump.
- HALT: all strobes 0, halted=1. Remains until reset.
- Strobe and handshake rules:
  - pc_inc and pc_load are never asserted in the same cycle.
  - Every strobe is combinational from state/ir/mem_ready, valid for exactly one clk.
  - mem_rd and mem_wr are never both 1.
  - mem_addr and mem_rd/mem_wr are stable while waiting for ready.
  - mem_ready outside a request is ignored.
- Flags are sampled in EXEC only; flag changes during the prior waits are irrelevant.
- PC wrap: the sequencer does not check it; a 0xFF to 0x00 increment is the counter's behaviour.
- Latency with mem_ready tied 1:
  - 1-byte op: 2 cycles.
  - LDI/JMP/JC/JZ: 4 cycles.
  - LDA/ADD/SUB/STA: 4 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Shared package cpu_pkg: opcode constants, state encoding (3-bit), the is_two_byte/is_mem_op decode helpers.
- No sub-module. A single FSM plus the ir/opr registers in one file. The existing PC counter instance stays outside, wired to pc_inc/pc_load.

Test Plan:
- Reset: hold reset=0 mid-FETCH with mem_rd=1 -> mem_rd drops immediately, all strobes 0. Release -> FETCH with mem_addr=pc.
- Memory program at 0 = {51,2A,E0,F0}, ready=1 -> a_load with a_src=1 at cycle 4, out_load at cycle 6, halted=1 at cycle 8 and held for 20 cycles.
- Memory {10,80}, mem[80]=33, mem_ready delayed 3 cycles on each access -> addresses 00, 01, 80 stable during waits; one ir_load, two pc_inc, a_load with a_src=0 on the final ready cycle.
- JC 40 with flag_c=0 -> no pc_load, next fetch at PC+2. With flag_c=1 -> pc_load=1, pc_load_val=40 in EXEC.
- STA 90 -> mem_wr=1 with mem_addr=90 until ready, mem_rd=0 throughout EXEC_MEM.
- Undefined opcode B0 -> 2-cycle NOP, no memory access in DECODE, one pc_inc total.
